memory_ctrl: RTL and testbench

- Parametrised successor to the core's single-port data/instruction memory.
- Adds configurable width, depth and read latency; a valid/ready request handshake; per-bit write masking; and a sequential clear engine that replaces the single-cycle array reset.
- Sits between the CPU core load/store unit and the storage array.
- Fully pipelined: one request per cycle when ready.

---
 rtl/memory_ctrl.sv | 135 +++++++++++++
 tb/tb_memory_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_ctrl.sv
// memory_ctrl: parametrised single-port word memory with valid/ready requests,
// per-bit write masking, a fixed-latency read pipeline and a sequential clear
// engine that walks the whole array after reset or on a clear request.
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   clear                   request to zero the whole array (honoured in READY)
//   req_valid / req_ready   request handshake; accept = req_valid && req_ready
//   req_write               1 = masked write, 0 = read
//   req_address             word address (>= MEM_DEPTH is out of range)
//   req_data / req_mask     write data and per-bit write enable
//   rsp_valid / rsp_data    one-cycle read response, READ_LATENCY after accept
//   busy                    clear sequence in progress
//   error                   sticky out-of-range flag, cleared by reset or clear
//
// state | meaning
// CLEAR | zeroing mem[clear_ptr] each edge, requests refused
// READY | accepting one request per cycle
module memory_ctrl #(
    parameter int WORD_SIZE    = 16,
    parameter int ADDR_SIZE    = 5,
    parameter int MEM_DEPTH    = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [ADDR_SIZE-1:0] req_address,
    input  logic [WORD_SIZE-1:0] req_data,
    input  logic [WORD_SIZE-1:0] req_mask,
    output logic                 rsp_valid,
    output logic [WORD_SIZE-1:0] rsp_data,
    output logic                 busy,
    output logic                 error
);

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    localparam logic [ADDR_SIZE:0]   DEPTH_W   = (ADDR_SIZE+1)'(MEM_DEPTH);
    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);

    state_t                 state;
    logic [ADDR_SIZE-1:0]   clear_ptr;
    logic [WORD_SIZE-1:0]   mem [MEM_DEPTH];
    logic [READ_LATENCY-1:0] pipe_valid;
    logic [WORD_SIZE-1:0]   pipe_data [READ_LATENCY];

    logic                   accept;
    logic                   in_range;
    logic                   rd_accept;
    logic [WORD_SIZE-1:0]   rd_word;

    assign req_ready = (state == ST_READY) && !clear;
    assign accept    = req_valid && req_ready;
    assign in_range  = {1'b0, req_address} < DEPTH_W;
    assign rd_accept = accept && !req_write;
    assign rd_word   = in_range ? mem[req_address] : '0;

    // Storage array: no reset, so a held reset leaves the contents untouched
    // and the clear engine restarts from address 0 once reset drops.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state == ST_CLEAR) begin
                mem[clear_ptr] <= '0;
            end else if (accept && req_write && in_range) begin
                mem[req_address] <= (mem[req_address] & ~req_mask) | (req_data & req_mask);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_CLEAR;
            clear_ptr <= '0;
            busy      <= 1'b1;
            error     <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    if (clear_ptr == LAST_ADDR) begin
                        state     <= ST_READY;
                        busy      <= 1'b0;
                        clear_ptr <= '0;
                    end else begin
                        clear_ptr <= clear_ptr + 1'b1;
                    end
                end
                ST_READY: begin
                    if (clear) begin
                        state     <= ST_CLEAR;
                        busy      <= 1'b1;
                        clear_ptr <= '0;
                        error     <= 1'b0;
                    end else if (accept && !in_range) begin
                        error <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_CLEAR;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

    // Read pipeline: each stage only loads data when a valid token moves in,
    // so the last stage holds the previous response while rsp_valid is low.
    // A clear does not touch it; reads in flight finish with pre-clear data.
    always_ff @(posedge clock) begin
        if (reset) begin
            pipe_valid <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_data[i] <= '0;
            end
        end else begin
            pipe_valid[0] <= rd_accept;
            if (rd_accept) begin
                pipe_data[0] <= rd_word;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                if (pipe_valid[i-1]) begin
                    pipe_data[i] <= pipe_data[i-1];
                end
            end
        end
    end

    assign rsp_valid = pipe_valid[READ_LATENCY-1];
    assign rsp_data  = pipe_data[READ_LATENCY-1];

endmodule

// File: tb/tb_memory_ctrl.sv
// Directed bench for memory_ctrl. Instance 0: 32 words, read latency 3.
// Instance 1: 20 words, read latency 2 (out-of-range and clear-in-flight cases).
module tb_memory_ctrl;

    logic        clock = 1'b0;
    logic [1:0]  reset;
    logic [1:0]  clear;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_write;
    logic [4:0]  req_address [2];
    logic [15:0] req_data [2];
    logic [15:0] req_mask [2];
    logic [1:0]  rsp_valid;
    logic [15:0] rsp_data [2];
    logic [1:0]  busy;
    logic [1:0]  error;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    always #5 clock = ~clock;

    memory_ctrl #(.WORD_SIZE(16), .ADDR_SIZE(5), .MEM_DEPTH(32), .READ_LATENCY(3)) u_a (
        .clock(clock), .reset(reset[0]), .clear(clear[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_address(req_address[0]), .req_data(req_data[0]), .req_mask(req_mask[0]),
        .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]),
        .busy(busy[0]), .error(error[0])
    );

    memory_ctrl #(.WORD_SIZE(16), .ADDR_SIZE(5), .MEM_DEPTH(20), .READ_LATENCY(2)) u_b (
        .clock(clock), .reset(reset[1]), .clear(clear[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_address(req_address[1]), .req_data(req_data[1]), .req_mask(req_mask[1]),
        .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]),
        .busy(busy[1]), .error(error[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic do_write(input int u, input logic [4:0] a, input logic [15:0] d,
                            input logic [15:0] m);
        req_valid[u]   = 1'b1;
        req_write[u]   = 1'b1;
        req_address[u] = a;
        req_data[u]    = d;
        req_mask[u]    = m;
        step();
        req_valid[u] = 1'b0;
        req_write[u] = 1'b0;
    endtask

    // lat = number of cycles from the accept edge to the sampled response
    task automatic do_read(input int u, input logic [4:0] a, output logic [15:0] d,
                           output int lat);
        req_valid[u]   = 1'b1;
        req_write[u]   = 1'b0;
        req_address[u] = a;
        step();
        req_valid[u] = 1'b0;
        lat = 1;
        while (!rsp_valid[u] && lat < 12) begin
            step();
            lat++;
        end
        d = rsp_data[u];
    endtask

    logic [15:0] d;
    logic [15:0] acc;
    int lat, c0, c1, bad, extra;

    initial begin
        reset     = 2'b11;
        clear     = 2'b00;
        req_valid = 2'b00;
        req_write = 2'b00;
        for (int i = 0; i < 2; i++) begin
            req_address[i] = '0;
            req_data[i]    = '0;
            req_mask[i]    = '0;
        end
        step();
        step();

        chk("rst_busy",      {30'd0, busy},      32'h3);
        chk("rst_ready",     {30'd0, req_ready}, 32'h0);
        chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'h0);
        chk("rst_error",     {30'd0, error},     32'h0);
        chk("rst_rsp_data",  {16'd0, rsp_data[0]}, 32'h0);

        // Reset-clear timing on both instances
        reset = 2'b00;
        c0 = 0; c1 = 0; bad = 0;
        for (int n = 0; n < 100; n++) begin
            if (!busy[0] && !busy[1]) break;
            if (busy[0]) c0++;
            if (busy[1]) c1++;
            if ((busy[0] && req_ready[0]) || (busy[1] && req_ready[1])) bad++;
            step();
        end
        chk("clear_cycles_32", c0, 32);
        chk("clear_cycles_20", c1, 20);
        chk("ready_low_in_clear", bad, 0);
        chk("ready_after_clear", {30'd0, req_ready}, 32'h3);

        acc = '0; bad = 0;
        for (int a = 0; a < 32; a++) begin
            do_read(0, 5'(a), d, lat);
            acc |= d;
            if (lat != 3) bad++;
        end
        chk("sweep_all_zero", {16'd0, acc}, 32'h0);
        chk("sweep_latency", bad, 0);

        // Masked write and latency
        do_write(0, 5'd5, 16'hFFFF, 16'hFFFF);
        do_write(0, 5'd5, 16'h1234, 16'h00FF);
        do_read(0, 5'd5, d, lat);
        chk("mask_data", {16'd0, d}, 32'hFF34);
        chk("mask_latency", lat, 3);
        step();
        chk("rsp_one_pulse", {31'd0, rsp_valid[0]}, 32'h0);
        chk("rsp_data_hold", {16'd0, rsp_data[0]}, 32'hFF34);

        // Pipelined back-to-back reads
        do_write(0, 5'd0, 16'hA000, 16'hFFFF);
        do_write(0, 5'd1, 16'hA001, 16'hFFFF);
        do_write(0, 5'd2, 16'hA002, 16'hFFFF);
        req_valid[0] = 1'b1;
        req_write[0] = 1'b0;
        req_address[0] = 5'd0; step();
        req_address[0] = 5'd1; step();
        req_address[0] = 5'd2; step();
        req_valid[0] = 1'b0;
        chk("pipe0_valid", {31'd0, rsp_valid[0]}, 32'h1);
        chk("pipe0_data", {16'd0, rsp_data[0]}, 32'hA000);
        step();
        chk("pipe1_valid", {31'd0, rsp_valid[0]}, 32'h1);
        chk("pipe1_data", {16'd0, rsp_data[0]}, 32'hA001);
        step();
        chk("pipe2_valid", {31'd0, rsp_valid[0]}, 32'h1);
        chk("pipe2_data", {16'd0, rsp_data[0]}, 32'hA002);
        step();
        chk("pipe_end", {31'd0, rsp_valid[0]}, 32'h0);

        // Reset one cycle after a read accept: response must never appear
        req_valid[0] = 1'b1;
        req_write[0] = 1'b0;
        req_address[0] = 5'd5;
        step();
        req_valid[0] = 1'b0;
        reset[0] = 1'b1;
        step();
        reset[0] = 1'b0;
        c0 = 0; extra = 0;
        for (int n = 0; n < 100; n++) begin
            if (rsp_valid[0]) extra++;
            if (!busy[0]) break;
            c0++;
            step();
        end
        chk("midreset_no_rsp", extra, 0);
        chk("midreset_clear_cycles", c0, 32);
        do_read(0, 5'd5, d, lat);
        chk("midreset_cleared", {16'd0, d}, 32'h0);

        // Out-of-range on the 20-word instance
        do_write(1, 5'd25, 16'hBEEF, 16'hFFFF);
        chk("oor_error_set", {31'd0, error[1]}, 32'h1);
        do_read(1, 5'd25, d, lat);
        chk("oor_read_zero", {16'd0, d}, 32'h0);
        chk("oor_read_latency", lat, 2);
        do_read(1, 5'd5, d, lat);
        chk("oor_no_alias", {16'd0, d}, 32'h0);
        do_write(1, 5'd19, 16'h1919, 16'hFFFF);
        do_read(1, 5'd19, d, lat);
        chk("last_addr_data", {16'd0, d}, 32'h1919);
        chk("error_sticky", {31'd0, error[1]}, 32'h1);
        clear[1] = 1'b1;
        step();
        clear[1] = 1'b0;
        chk("clear_error_low", {31'd0, error[1]}, 32'h0);
        c1 = 0;
        for (int n = 0; n < 100; n++) begin
            if (!busy[1]) break;
            c1++;
            step();
        end
        chk("clear_pulse_cycles", c1, 20);
        do_read(1, 5'd19, d, lat);
        chk("clear_pulse_zeroed", {16'd0, d}, 32'h0);

        // Clear while a read is in flight
        do_write(1, 5'd3, 16'h5555, 16'hFFFF);
        req_valid[1] = 1'b1;
        req_write[1] = 1'b0;
        req_address[1] = 5'd3;
        step();
        clear[1] = 1'b1;
        #1;
        chk("ready_low_on_clear", {31'd0, req_ready[1]}, 32'h0);
        chk("inflight_not_yet", {31'd0, rsp_valid[1]}, 32'h0);
        step();
        chk("inflight_valid", {31'd0, rsp_valid[1]}, 32'h1);
        chk("inflight_data", {16'd0, rsp_data[1]}, 32'h5555);
        chk("inflight_busy", {31'd0, busy[1]}, 32'h1);
        clear[1] = 1'b0;
        req_valid[1] = 1'b0;
        extra = 0;
        bad = 1;
        for (int n = 0; n < 100; n++) begin
            step();
            if (rsp_valid[1]) extra++;
            if (!busy[1]) begin
                bad = 0;
                break;
            end
        end
        chk("inflight_busy_falls", bad, 0);
        chk("inflight_no_extra_rsp", extra, 0);
        do_read(1, 5'd3, d, lat);
        chk("inflight_after_clear", {16'd0, d}, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
